// File: rtl/loom_dpi_sched.sv
// loom_dpi_sched: service scheduler for the DPI register file.
// Freezes the DUT clock while any DPI function is stalled, grants stalled
// functions one at a time in round-robin order, raises a host interrupt for
// each grant, and releases the DUT clock only when no function is stalled.
module loom_dpi_sched #(
    parameter int N_DPI_FUNCS    = 4,
    parameter int FREEZE_DELAY   = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int IDX_W          = (N_DPI_FUNCS > 1) ? $clog2(N_DPI_FUNCS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [N_DPI_FUNCS-1:0] stall_i,
    input  logic                   irq_ack_i,
    output logic                   dut_clk_en_o,
    output logic                   irq_o,
    output logic                   cur_valid_o,
    output logic [IDX_W-1:0]       cur_idx_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    // Counter widths sized to the largest value each counter must hold.
    localparam int FD_W = (FREEZE_DELAY > 1) ? $clog2(FREEZE_DELAY + 1) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FD_W-1:0]  FD_INIT  = FD_W'(FREEZE_DELAY);
    localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DPI_FUNCS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FREEZE,
        ST_NOTIFY,
        ST_SERVICE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [FD_W-1:0]  frz_cnt;
    logic [WD_W-1:0]  wd_cnt;

    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] grant_rr;
    logic [IDX_W-1:0] upper_idx;
    logic [IDX_W-1:0] lower_idx;
    logic             upper_hit;
    logic             any_stall;
    logic             cur_done;
    logic             grant_point;
    logic             do_grant;

    // Round-robin arbiter: lowest stalled index at or above rr_ptr, otherwise
    // wrap around to the lowest stalled index overall.
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        upper_idx = '0;
        lower_idx = '0;
        upper_hit = 1'b0;
        // Scanning downward leaves the lowest matching index in each slot.
        for (int j = N_DPI_FUNCS - 1; j >= 0; j--) begin
            if (stall_i[j]) begin
                lower_idx = IDX_W'(j);
                if (IDX_W'(j) >= rr_ptr) begin
                    upper_idx = IDX_W'(j);
                    upper_hit = 1'b1;
                end
            end
        end
        grant_idx = upper_hit ? upper_idx : lower_idx;
        grant_rr  = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
    end

    // Grant decision: end of the freeze window, or the serviced function has
    // finished; a grant only happens if something is still stalled.
    always_comb begin
        any_stall   = |stall_i;
        cur_done    = ~stall_i[cur_idx_o];
        grant_point = ((state == ST_FREEZE) && (frz_cnt == '0)) ||
                      ((state == ST_SERVICE) && cur_done);
        do_grant    = grant_point && any_stall;
    end

    // Scheduler FSM with registered outputs, watchdog and grant bookkeeping.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and later assignments in this block
    // (e.g. the watchdog clear on grant) cleanly override earlier ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            frz_cnt      <= '0;
            wd_cnt       <= '0;
            dut_clk_en_o <= 1'b1;
            irq_o        <= 1'b0;
            cur_valid_o  <= 1'b0;
            cur_idx_o    <= '0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            timeout_o <= 1'b0;

            // Service-time watchdog: runs while a function is notified or in
            // service; saturates when disabled so it never wraps.
            if ((state == ST_NOTIFY) || (state == ST_SERVICE)) begin
                if (TIMEOUT_CYCLES != 0) begin
                    if (wd_cnt == WD_LAST) begin
                        timeout_o <= 1'b1;
                        wd_cnt    <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end else if (wd_cnt != '1) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (en_i && any_stall) begin
                        state        <= ST_FREEZE;
                        frz_cnt      <= FD_INIT;
                        dut_clk_en_o <= 1'b0;
                        busy_o       <= 1'b1;
                    end
                end

                ST_FREEZE: begin
                    if (frz_cnt != '0) begin
                        frz_cnt <= frz_cnt - FD_W'(1);
                    end else if (!any_stall) begin
                        // Every call resolved while settling: release quietly.
                        state        <= ST_IDLE;
                        dut_clk_en_o <= 1'b1;
                        busy_o       <= 1'b0;
                    end
                end

                ST_NOTIFY: begin
                    if (irq_ack_i) begin
                        state <= ST_SERVICE;
                        irq_o <= 1'b0;
                    end
                end

                ST_SERVICE: begin
                    if (cur_done && !any_stall) begin
                        state        <= ST_IDLE;
                        cur_valid_o  <= 1'b0;
                        dut_clk_en_o <= 1'b1;
                        busy_o       <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Shared grant path for FREEZE and back-to-back SERVICE grants;
            // the DUT clock stays gated across consecutive grants.
            if (do_grant) begin
                state       <= ST_NOTIFY;
                cur_idx_o   <= grant_idx;
                cur_valid_o <= 1'b1;
                rr_ptr      <= grant_rr;
                irq_o       <= 1'b1;
                wd_cnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_loom_dpi_sched.sv
// Self-checking bench for loom_dpi_sched: directed scenarios followed by
// randomized service episodes, compared against a behavioural model of the
// round-robin order and the documented cycle timing.
module tb_loom_dpi_sched;

    localparam int N  = 4;
    localparam int FD = 2;
    localparam int TO = 5;

    logic         clk_i     = 1'b0;
    logic         rst_ni    = 1'b0;
    logic         en_i      = 1'b0;
    logic [N-1:0] stall_i   = '0;
    logic         irq_ack_i = 1'b0;
    logic         dut_clk_en_o;
    logic         irq_o;
    logic         cur_valid_o;
    logic [1:0]   cur_idx_o;
    logic         busy_o;
    logic         timeout_o;

    int checks  = 0;
    int errors  = 0;
    int model_rr = 0;
    int last_g   = 0;

    always #5 clk_i = ~clk_i;

    loom_dpi_sched #(
        .N_DPI_FUNCS    (N),
        .FREEZE_DELAY   (FD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .stall_i      (stall_i),
        .irq_ack_i    (irq_ack_i),
        .dut_clk_en_o (dut_clk_en_o),
        .irq_o        (irq_o),
        .cur_valid_o  (cur_valid_o),
        .cur_idx_o    (cur_idx_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; all sampling and driving happens 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference round-robin: walk indices starting at ptr, modulo N.
    function automatic int rr_expect(input logic [N-1:0] v, input int ptr);
        for (int off = 0; off < N; off++) begin
            int k;
            k = (ptr + off) % N;
            if (((int'(v) >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    // Called on the cycle a grant becomes visible; stall_i still holds the
    // vector that was present at the grant edge.
    task automatic expect_grant(input string tag);
        int g;
        g = rr_expect(stall_i, model_rr);
        check({tag, "_idx"}, 32'(cur_idx_o), g);
        check({tag, "_valid"}, 32'(cur_valid_o), 1);
        check({tag, "_irq"}, 32'(irq_o), 1);
        check({tag, "_gated"}, 32'(dut_clk_en_o), 0);
        last_g   = g;
        model_rr = (g + 1) % N;
    endtask

    // Acknowledge the current grant, optionally raise new stalls, then clear
    // the served bit and check the following regrant or release.
    task automatic ack_and_release(input int ack_dly, input int drop_dly, input logic [N-1:0] add_bits);
        repeat (ack_dly) begin
            tick();
            check("irq_hold", 32'(irq_o), 1);
        end
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("irq_clear", 32'(irq_o), 0);
        check("busy_service", 32'(busy_o), 1);
        stall_i = stall_i | add_bits;
        repeat (drop_dly) tick();
        check("gated_service", 32'(dut_clk_en_o), 0);
        stall_i = stall_i & ~(N'(1) << last_g);
        tick();
        if (stall_i != '0) begin
            expect_grant("regrant");
        end else begin
            check("release_clk", 32'(dut_clk_en_o), 1);
            check("release_valid", 32'(cur_valid_o), 0);
            check("release_busy", 32'(busy_o), 0);
            check("release_irq", 32'(irq_o), 0);
        end
    endtask

    // Start an episode from IDLE and check the freeze latency and the first
    // grant at its exact cycle.
    task automatic start_episode(input logic [N-1:0] v, input string tag);
        stall_i = v;
        tick();
        check({tag, "_freeze"}, 32'(dut_clk_en_o), 0);
        repeat (FD + 1) tick();
        expect_grant(tag);
    endtask

    task automatic drain(input int ack_dly, input int drop_dly);
        for (int k = 0; k < 2 * N && stall_i != '0; k++)
            ack_and_release(ack_dly, drop_dly, '0);
        check("drained", 32'(stall_i), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset values.
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        en_i = 1'b1;
        tick();
        check("rst_clk_en", 32'(dut_clk_en_o), 1);
        check("rst_irq", 32'(irq_o), 0);
        check("rst_valid", 32'(cur_valid_o), 0);
        check("rst_idx", 32'(cur_idx_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);

        // Round-robin from rr=0: grants 0,1,3 with the clock gated throughout.
        start_episode(4'b1011, "rr");
        check("rr_first", 32'(last_g), 0);
        drain(1, 2);

        // Fairness wrap: after granting 3, 1001 grants 0 then 3.
        start_episode(4'b1001, "wrap");
        check("wrap_first", 32'(last_g), 0);
        ack_and_release(0, 1, '0);
        check("wrap_second", 32'(last_g), 3);
        drain(0, 0);

        // Single call with exact cycle timing; en_i drop mid-episode ignored.
        stall_i = 4'b0100;                       // cycle 0
        tick();                                  // cycle 1
        check("sc_clk_off_c1", 32'(dut_clk_en_o), 0);
        check("sc_busy_c1", 32'(busy_o), 1);
        check("sc_irq_c1", 32'(irq_o), 0);
        tick();                                  // cycle 2
        en_i = 1'b0;
        tick();                                  // cycle 3
        check("sc_irq_c3", 32'(irq_o), 0);
        tick();                                  // cycle 4
        expect_grant("sc_c4");
        tick();                                  // cycle 5
        tick();                                  // cycle 6
        irq_ack_i = 1'b1;
        tick();                                  // cycle 7
        irq_ack_i = 1'b0;
        check("sc_irq_c7", 32'(irq_o), 0);
        tick();                                  // cycle 8
        check("sc_to_c8", 32'(timeout_o), 0);
        tick();                                  // cycle 9: 5 after NOTIFY entry
        check("sc_to_c9", 32'(timeout_o), 1);
        tick();                                  // cycle 10
        check("sc_to_c10", 32'(timeout_o), 0);
        stall_i = 4'b0000;
        tick();                                  // cycle 11
        check("sc_clk_on_c11", 32'(dut_clk_en_o), 1);
        check("sc_valid_c11", 32'(cur_valid_o), 0);
        check("sc_busy_c11", 32'(busy_o), 0);

        // Enable gating: stall held with en_i=0 never freezes.
        stall_i = 4'b0001;
        repeat (4) begin
            tick();
            check("en_off_clk", 32'(dut_clk_en_o), 1);
            check("en_off_busy", 32'(busy_o), 0);
        end
        en_i = 1'b1;
        tick();
        check("en_on_freeze", 32'(dut_clk_en_o), 0);
        repeat (FD + 1) tick();
        expect_grant("en_on");
        drain(0, 0);

        // Watchdog: ack withheld, pulses 5 and 10 cycles after NOTIFY entry.
        start_episode(4'b0010, "wd");
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("wd_pulse", 32'(timeout_o), (i == 5 || i == 10) ? 1 : 0);
            check("wd_irq", 32'(irq_o), 1);
        end
        drain(0, 0);

        // Stall vanishes during FREEZE: release with no interrupt, no grant.
        stall_i = 4'b0010;
        tick();
        stall_i = 4'b0000;
        repeat (FD + 1) tick();
        check("abort_clk", 32'(dut_clk_en_o), 1);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_irq", 32'(irq_o), 0);
        check("abort_valid", 32'(cur_valid_o), 0);

        // Granted bit drops in NOTIFY: ack still required, then fast exit.
        start_episode(4'b0100, "ndrop");
        stall_i = 4'b0000;
        repeat (2) begin
            tick();
            check("ndrop_irq_hold", 32'(irq_o), 1);
        end
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("ndrop_irq_clr", 32'(irq_o), 0);
        check("ndrop_gated", 32'(dut_clk_en_o), 0);
        tick();
        check("ndrop_clk_on", 32'(dut_clk_en_o), 1);
        check("ndrop_valid", 32'(cur_valid_o), 0);

        // Asynchronous reset in SERVICE; rr pointer restarts at 0 afterwards.
        start_episode(4'b0001, "rst_ep");
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        stall_i = 4'b0011;
        #3 rst_ni = 1'b0;
        #1;
        check("arst_clk", 32'(dut_clk_en_o), 1);
        check("arst_irq", 32'(irq_o), 0);
        check("arst_valid", 32'(cur_valid_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check("arst_idx", 32'(cur_idx_o), 0);
        #2 rst_ni = 1'b1;
        model_rr = 0;
        tick();
        check("post_rst_freeze", 32'(dut_clk_en_o), 0);
        repeat (FD + 1) tick();
        expect_grant("post_rst");
        check("post_rst_first", 32'(last_g), 0);
        drain(1, 1);

        // Randomized episodes with late-arriving stall bits.
        for (int ep = 0; ep < 25; ep++) begin
            int budget;
            budget = 2;
            start_episode(N'($urandom_range(1, (1 << N) - 1)), "rand");
            for (int k = 0; k < 4 * N && stall_i != '0; k++) begin
                logic [N-1:0] add;
                add = '0;
                if (budget > 0 && $urandom_range(0, 2) == 0) begin
                    add = N'($urandom_range(0, (1 << N) - 1));
                    budget--;
                end
                ack_and_release($urandom_range(0, 3), $urandom_range(0, 3), add);
            end
            check("rand_drained", 32'(stall_i), 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
